branch_feedback_unit: RTL and testbench
=======================================

Name: branch_feedback_unit

Overview:
- Producer side of the predictor request/feedback interface.
- Records every prediction issued at decode in an in-order queue and matches each one with its resolved outcome from execute.
- Drives registered feedback (valid, pc, prediction, outcome) into the predictor and raises a misprediction redirect with its recovery target.
- Keeps saturating prediction and miss statistics counters.

Parameters:
ADDR_W, 32, width of PC and target fields
DEPTH, 4, number of in-flight predictions (power of 2, at least 2)
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  clock
rst_n  in  1  reset
i_req_valid  in  1  decode issued a conditional-branch prediction this cycle
i_req_pc  in  ADDR_W  PC of the predicted branch
i_req_target  in  ADDR_W  taken target of the branch
i_req_prediction  in  1  predicted outcome (mips_core_pkg::BranchOutcome, TAKEN=1)
i_res_valid  in  1  execute resolved the oldest outstanding branch
i_res_outcome  in  1  actual outcome (BranchOutcome)
i_flush  in  1  external squash of all in-flight entries
o_full  out  1  queue full; hazard logic stalls decode
o_count  out  $clog2(DEPTH+1)  occupancy
o_fb_valid  out  1  feedback strobe to predictor
o_fb_pc  out  ADDR_W  feedback PC
o_fb_prediction  out  1  stored prediction
o_fb_outcome  out  1  actual outcome
o_redirect_valid  out  1  misprediction; fetch must redirect
o_redirect_target  out  ADDR_W  recovery PC
o_pred_count  out  CNT_W  resolved branches
o_miss_count  out  CNT_W  mispredicted branches
o_err  out  1  sticky protocol error

Behaviour:
- Reset: rst_n is synchronous and active-low; clk is the clock. Reset clears the queue (count=0, pointers=0) and sets every output to 0, with o_full=0.
- Reset mid-operation discards all entries. No feedback is emitted for them.
- Queue: circular buffer with read and write pointers that wrap modulo DEPTH. Each entry holds {pc, target, prediction}.
- o_full = (count==DEPTH). Both o_full and o_count are combinational from registered state.
- Push: happens when i_req_valid and (not full, or a pop occurs in the same cycle).
  - A push on full without a pop is dropped and sets o_err.
- Pop: happens when i_res_valid and count>0.
  - A resolve on empty is ignored and sets o_err. No feedback is produced.
- Feedback latency is 1 cycle. The cycle after a pop:
  - o_fb_valid=1.
  - o_fb_pc, o_fb_prediction and o_fb_outcome come from the head entry and i_res_outcome.
  - o_fb_valid is a single-cycle pulse per pop. The data fields hold their last values while o_fb_valid=0.
- Mispredict: occurs when the popped entry's prediction differs from i_res_outcome.
  - The next cycle: o_redirect_valid=1 (1-cycle pulse).
  - o_redirect_target = pc+8 if the outcome was NOT_TAKEN, otherwise the stored target. Arithmetic wraps modulo 2^ADDR_W.
  - In the pop cycle all remaining entries are cleared (they are younger and on the wrong path), and any same-cycle push is dropped without setting o_err.
- i_flush: clears all entries and drops a same-cycle push.
  - A same-cycle resolve is still processed first: feedback and redirect are emitted normally.
- Counters are updated in the cycle feedback is emitted:
  - o_pred_count +1 per feedback.
  - o_miss_count +1 per redirect.
  - Both saturate at all-ones and never wrap.
- o_err clears only on reset.
- No combinational path from any input to any output except through o_full/o_count, which depend on state only.

Test Plan:
- Reset, then push pc=0x100, tgt=0x80, pred=TAKEN; one cycle later resolve TAKEN -> next cycle o_fb_valid=1, fb_pc=0x100, prediction=outcome=1; no redirect; pred_count=1, miss_count=0.
- Push pc=0x200, tgt=0x300, pred=NOT_TAKEN, then push pc=0x210; resolve TAKEN -> redirect_valid=1, target=0x300; count=0 (0x210 squashed); miss_count=1.
- Push pred=TAKEN, pc=0x400; resolve NOT_TAKEN -> redirect_target=0x408.
- Fill 4 entries (0x10,0x20,0x30,0x40) -> o_full=1. Push 0x50 with no resolve -> dropped, o_err=1. Resolve and push 0x50 in the same cycle -> accepted, count stays 4. Four correct resolves -> fb_pc sequence 0x20,0x30,0x40,0x50.
- Resolve on empty -> no o_fb_valid, o_err=1. Flush together with resolve and push with 2 entries -> one feedback, count=0.
- Assert rst_n=0 with 3 entries in the queue -> next cycle count=0, all outputs 0, no feedback. Preload the counters to all-ones -> a further miss keeps the counters at all-ones.

Source files
------------

// File: rtl/branch_feedback_unit.sv
// Branch feedback unit: in-order queue of decode predictions matched to
// execute resolutions, driving predictor feedback, redirects and stats.
module branch_feedback_unit #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_req_valid,
    input  logic [ADDR_W-1:0]          i_req_pc,
    input  logic [ADDR_W-1:0]          i_req_target,
    input  logic                       i_req_prediction,
    input  logic                       i_res_valid,
    input  logic                       i_res_outcome,
    input  logic                       i_flush,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_fb_valid,
    output logic [ADDR_W-1:0]          o_fb_pc,
    output logic                       o_fb_prediction,
    output logic                       o_fb_outcome,
    output logic                       o_redirect_valid,
    output logic [ADDR_W-1:0]          o_redirect_target,
    output logic [CNT_W-1:0]           o_pred_count,
    output logic [CNT_W-1:0]           o_miss_count,
    output logic                       o_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [PW-1:0]     P_ONE   = PW'(1);
    localparam logic [CW-1:0]     C_ONE   = CW'(1);
    localparam logic [CW-1:0]     C_FULL  = CW'(DEPTH);
    localparam logic [CNT_W-1:0]  N_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(8);

    logic [ADDR_W-1:0] q_pc  [DEPTH];
    logic [ADDR_W-1:0] q_tgt [DEPTH];
    logic [DEPTH-1:0]  q_pred;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    logic pop;
    logic push;
    logic mispred;
    logic squash;
    logic err_set;

    assign o_full  = (cnt == C_FULL);
    assign o_count = cnt;

    always_comb begin
        pop     = 1'b0;
        mispred = 1'b0;
        squash  = 1'b0;
        push    = 1'b0;
        err_set = 1'b0;

        pop     = i_res_valid && (cnt != '0);
        mispred = pop && (q_pred[rd_ptr] != i_res_outcome);
        // Younger entries sit on the wrong path after a miss or a flush.
        squash  = mispred || i_flush;
        push    = i_req_valid && (!o_full || pop) && !squash;

        if (i_res_valid && (cnt == '0))
            err_set = 1'b1;
        if (i_req_valid && o_full && !pop && !squash)
            err_set = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= i_req_pc;
            q_tgt[wr_ptr]  <= i_req_target;
            q_pred[wr_ptr] <= i_req_prediction;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (squash) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + P_ONE;
            if (push)
                wr_ptr <= wr_ptr + P_ONE;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + C_ONE;
                2'b01:   cnt <= cnt - C_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_fb_valid        <= 1'b0;
            o_fb_pc           <= '0;
            o_fb_prediction   <= 1'b0;
            o_fb_outcome      <= 1'b0;
            o_redirect_valid  <= 1'b0;
            o_redirect_target <= '0;
            o_pred_count      <= '0;
            o_miss_count      <= '0;
            o_err             <= 1'b0;
        end else begin
            o_fb_valid       <= pop;
            o_redirect_valid <= mispred;
            if (pop) begin
                o_fb_pc         <= q_pc[rd_ptr];
                o_fb_prediction <= q_pred[rd_ptr];
                o_fb_outcome    <= i_res_outcome;
                if (o_pred_count != '1)
                    o_pred_count <= o_pred_count + N_ONE;
            end
            if (mispred) begin
                o_redirect_target <= i_res_outcome ? q_tgt[rd_ptr]
                                                   : q_pc[rd_ptr] + PC_STEP;
                if (o_miss_count != '1)
                    o_miss_count <= o_miss_count + N_ONE;
            end
            if (err_set)
                o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_feedback_unit.sv
// Directed bench for branch_feedback_unit with a queue-based reference
// model; a second instance with narrow counters exercises saturation.
module tb_branch_feedback_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_pc = '0;
    logic [31:0] req_tgt = '0;
    logic        req_pred = 1'b0;
    logic        res_valid = 1'b0;
    logic        res_out = 1'b0;
    logic        flush = 1'b0;

    logic        full, fb_valid, fb_pred, fb_out, rd_valid, err;
    logic [2:0]  count;
    logic [31:0] fb_pc, rd_tgt, pred_cnt, miss_cnt;

    logic        s_full, s_fb_valid, s_fb_pred, s_fb_out, s_rd_valid, s_err;
    logic [2:0]  s_count;
    logic [31:0] s_fb_pc, s_rd_tgt;
    logic [1:0]  s_pred_cnt, s_miss_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_feedback_unit u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_pc(req_pc),
        .i_req_target(req_tgt), .i_req_prediction(req_pred),
        .i_res_valid(res_valid), .i_res_outcome(res_out),
        .i_flush(flush),
        .o_full(full), .o_count(count),
        .o_fb_valid(fb_valid), .o_fb_pc(fb_pc),
        .o_fb_prediction(fb_pred), .o_fb_outcome(fb_out),
        .o_redirect_valid(rd_valid), .o_redirect_target(rd_tgt),
        .o_pred_count(pred_cnt), .o_miss_count(miss_cnt),
        .o_err(err)
    );

    branch_feedback_unit #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_pc(req_pc),
        .i_req_target(req_tgt), .i_req_prediction(req_pred),
        .i_res_valid(res_valid), .i_res_outcome(res_out),
        .i_flush(flush),
        .o_full(s_full), .o_count(s_count),
        .o_fb_valid(s_fb_valid), .o_fb_pc(s_fb_pc),
        .o_fb_prediction(s_fb_pred), .o_fb_outcome(s_fb_out),
        .o_redirect_valid(s_rd_valid), .o_redirect_target(s_rd_tgt),
        .o_pred_count(s_pred_cnt), .o_miss_count(s_miss_cnt),
        .o_err(s_err)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pred;
    } ent_t;

    ent_t        q[$];
    bit          m_ready = 0;
    bit          e_fb_valid, e_fb_pred, e_fb_out, e_rd_valid, e_err;
    logic [31:0] e_fb_pc, e_rd_tgt;
    longint      n_pred, n_miss;

    function automatic longint sat(input longint v, input longint lim);
        return (v > lim) ? lim : v;
    endfunction

    always @(posedge clk) begin
        bit   popped, miss, was_full;
        ent_t e;
        m_ready = 1;
        if (!rst_n) begin
            q.delete();
            e_fb_valid = 0; e_fb_pred = 0; e_fb_out = 0;
            e_rd_valid = 0; e_err = 0;
            e_fb_pc = '0; e_rd_tgt = '0;
            n_pred = 0; n_miss = 0;
        end else begin
            was_full = (q.size() == DEPTH);
            popped = 0;
            miss = 0;
            e_fb_valid = 0;
            e_rd_valid = 0;
            if (res_valid && q.size() == 0)
                e_err = 1;
            if (res_valid && q.size() > 0) begin
                e = q.pop_front();
                popped = 1;
                e_fb_valid = 1;
                e_fb_pc = e.pc;
                e_fb_pred = e.pred;
                e_fb_out = res_out;
                n_pred++;
                if (e.pred != res_out) begin
                    miss = 1;
                    e_rd_valid = 1;
                    e_rd_tgt = res_out ? e.tgt : e.pc + 32'd8;
                    n_miss++;
                    q.delete();
                end
            end
            if (flush)
                q.delete();
            if (req_valid && !miss && !flush) begin
                if (was_full && !popped)
                    e_err = 1;
                else
                    q.push_back('{pc: req_pc, tgt: req_tgt, pred: req_pred});
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            chk("count", count, q.size());
            chk("full", full, q.size() == DEPTH);
            chk("fb_valid", fb_valid, e_fb_valid);
            chk("fb_pc", fb_pc, e_fb_pc);
            chk("fb_pred", fb_pred, e_fb_pred);
            chk("fb_out", fb_out, e_fb_out);
            chk("rd_valid", rd_valid, e_rd_valid);
            chk("rd_tgt", rd_tgt, e_rd_tgt);
            chk("pred_cnt", pred_cnt, sat(n_pred, 64'hFFFF_FFFF));
            chk("miss_cnt", miss_cnt, sat(n_miss, 64'hFFFF_FFFF));
            chk("err", err, e_err);
            chk("s_fb_valid", s_fb_valid, e_fb_valid);
            chk("s_pred_cnt", s_pred_cnt, sat(n_pred, 3));
            chk("s_miss_cnt", s_miss_cnt, sat(n_miss, 3));
        end
    end

    task automatic step(input logic rq, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic pr,
                        input logic rs, input logic oc, input logic fl);
        req_valid = rq; req_pc = pc; req_tgt = tgt; req_pred = pr;
        res_valid = rs; res_out = oc; flush = fl;
        @(negedge clk);
        req_valid = 0; res_valid = 0; flush = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pr);
        step(1, pc, tgt, pr, 0, 0, 0);
    endtask

    task automatic resolve(input logic oc);
        step(0, 0, 0, 0, 1, oc, 0);
    endtask

    initial begin
        @(negedge clk);
        idle();
        idle();
        chk("rst_count", count, 0);
        chk("rst_fb_valid", fb_valid, 0);
        rst_n = 1;

        push(32'h100, 32'h80, 1);
        resolve(1);
        chk("t1_fb_valid", fb_valid, 1);
        chk("t1_fb_pc", fb_pc, 32'h100);
        chk("t1_rd_valid", rd_valid, 0);
        chk("t1_pred_cnt", pred_cnt, 1);
        chk("t1_miss_cnt", miss_cnt, 0);

        push(32'h200, 32'h300, 0);
        push(32'h210, 32'h220, 1);
        resolve(1);
        chk("t2_rd_valid", rd_valid, 1);
        chk("t2_rd_tgt", rd_tgt, 32'h300);
        chk("t2_count", count, 0);
        chk("t2_miss_cnt", miss_cnt, 1);

        push(32'h400, 32'h500, 1);
        resolve(0);
        chk("t3_rd_tgt", rd_tgt, 32'h408);

        push(32'h10, 32'h11, 1);
        push(32'h20, 32'h21, 1);
        push(32'h30, 32'h31, 1);
        push(32'h40, 32'h41, 1);
        chk("t4_full", full, 1);
        push(32'h50, 32'h51, 1);
        chk("t4_err", err, 1);
        chk("t4_count_drop", count, 4);
        step(1, 32'h50, 32'h51, 1, 1, 1, 0);
        chk("t4_count_swap", count, 4);
        chk("t4_fb0", fb_pc, 32'h10);
        resolve(1);
        chk("t4_fb1", fb_pc, 32'h20);
        resolve(1);
        chk("t4_fb2", fb_pc, 32'h30);
        resolve(1);
        chk("t4_fb3", fb_pc, 32'h40);
        resolve(1);
        chk("t4_fb4", fb_pc, 32'h50);

        push(32'h600, 32'h700, 0);
        resolve(1);
        push(32'h800, 32'h900, 1);
        resolve(0);
        chk("sat_miss", s_miss_cnt, 3);
        chk("sat_pred", s_pred_cnt, 3);
        chk("wide_miss", miss_cnt, 4);

        rst_n = 0;
        idle();
        rst_n = 1;
        resolve(1);
        chk("t5_no_fb", fb_valid, 0);
        chk("t5_err", err, 1);
        push(32'hA0, 32'hA1, 1);
        push(32'hB0, 32'hB1, 1);
        step(1, 32'h999, 32'h998, 1, 1, 1, 1);
        chk("t5_fb_valid", fb_valid, 1);
        chk("t5_fb_pc", fb_pc, 32'hA0);
        chk("t5_count", count, 0);
        idle();

        push(32'hC0, 32'hC1, 1);
        push(32'hD0, 32'hD1, 0);
        push(32'hE0, 32'hE1, 1);
        chk("t6_count3", count, 3);
        rst_n = 0;
        step(0, 0, 0, 0, 1, 1, 0);
        chk("t6_count", count, 0);
        chk("t6_fb_valid", fb_valid, 0);
        chk("t6_fb_pc", fb_pc, 0);
        chk("t6_pred_cnt", pred_cnt, 0);
        chk("t6_err", err, 0);
        rst_n = 1;
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
